// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared encodings for the accumulator CPU multicycle
//               controller: opcodes, ALU operations, ALU B-source select
//               and the 4-bit controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

  // Opcode map (4-bit IR opcode field)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_LDA  = 4'd4;
  localparam logic [3:0] OP_STA  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_JNZ  = 4'd8;   // extended set
  localparam logic [3:0] OP_OR   = 4'd9;   // extended set
  localparam logic [3:0] OP_XOR  = 4'd10;  // extended set
  localparam logic [3:0] OP_HALT = 4'd11;  // extended set

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  // ALU B-source select encodings
  localparam logic [1:0] BSRC_MDR = 2'b00;
  localparam logic [1:0] BSRC_ONE = 2'b01;

  // Controller states
  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_ALU = 4'd2,
    S_EX_LDA = 4'd3,
    S_EX_STA = 4'd4,
    S_EX_JMP = 4'd5,
    S_EX_BR  = 4'd6,
    S_HALT   = 4'd7,
    S_FAULT  = 4'd8
  } state_e;

  // States in which the controller waits on the memory ready handshake
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_IF) || (s == S_ID) || (s == S_EX_STA);
  endfunction

endpackage : acc_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Saturating count of consecutive not-ready cycles spent in a
//               memory-wait state. Flags expiry when the count is all-ones
//               and memory is still not ready.
// Ports       : clk_i, rst_i  - clock, synchronous active-high reset
//               active_i      - controller currently in a memory-wait state
//               ready_i       - memory ready handshake
//               expired_o     - wait limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Holding the count at zero outside wait states means every wait state is
  // entered with a clear counter; wait-to-wait transitions only happen with
  // ready high, which also clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = active_i && !ready_i && (cnt_q == CNT_MAX);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/acc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : acc_ctrl_fsm
// Description : Multicycle controller for the accumulator CPU. Fetch/decode/
//               execute sequencing with memory wait states and timeout fault,
//               optional extended opcodes, internal branch resolution and
//               HALT/resume.
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               opcode_i, zero_i      - IR opcode, accumulator-zero flag
//               mem_ready_i, resume_i - memory handshake, leave HALT
//               MemRead_o .. PCwrite_o - datapath / memory strobes & selects
//               halted_o, fault_o     - status
// Revision    : 1.0 - initial release
// ============================================================================
module acc_ctrl_fsm
  import acc_pkg::*;
#(
  parameter int WAIT_W     = 4,
  parameter bit TIMEOUT_EN = 1'b1,
  parameter bit ENABLE_EXT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  input  logic       resume_i,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IorD_o,
  output logic       ldIR_o,
  output logic       ldMDR_o,
  output logic       ldAcc_o,
  output logic       AccSrc_o,
  output logic       Asrc_o,
  output logic [1:0] Bsrc_o,
  output logic [2:0] ALUop_o,
  output logic       PCsrc_o,
  output logic       PCwrite_o,
  output logic       halted_o,
  output logic       fault_o
);

  state_e     state_q, state_d;
  logic [2:0] alu_q, alu_d;
  logic       sense_q, sense_d;   // 1 = branch on not-zero (JNZ)

  logic       w_expired;
  logic       w_timeout;
  state_e     w_dec_state;
  logic [2:0] w_dec_alu;
  logic       w_dec_sense;

  mem_wait_timer #(.WAIT_W(WAIT_W)) u_wait (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  (is_mem_wait(state_q)),
    .ready_i   (mem_ready_i),
    .expired_o (w_expired)
  );

  assign w_timeout = TIMEOUT_EN && w_expired;

  // Opcode decode, used only when ID completes
  always_comb begin
    w_dec_state = S_FAULT;
    w_dec_alu   = alu_q;
    w_dec_sense = sense_q;
    case (opcode_i)
      OP_ADD: begin w_dec_state = S_EX_ALU; w_dec_alu = ALU_ADD; end
      OP_SUB: begin w_dec_state = S_EX_ALU; w_dec_alu = ALU_SUB; end
      OP_AND: begin w_dec_state = S_EX_ALU; w_dec_alu = ALU_AND; end
      OP_NOT: begin w_dec_state = S_EX_ALU; w_dec_alu = ALU_NOT; end
      OP_LDA: w_dec_state = S_EX_LDA;
      OP_STA: w_dec_state = S_EX_STA;
      OP_JMP: w_dec_state = S_EX_JMP;
      OP_JZ:  begin w_dec_state = S_EX_BR; w_dec_sense = 1'b0; end
      OP_JNZ: if (ENABLE_EXT) begin w_dec_state = S_EX_BR; w_dec_sense = 1'b1; end
      OP_OR:  if (ENABLE_EXT) begin w_dec_state = S_EX_ALU; w_dec_alu = ALU_OR; end
      OP_XOR: if (ENABLE_EXT) begin w_dec_state = S_EX_ALU; w_dec_alu = ALU_XOR; end
      OP_HALT: if (ENABLE_EXT) w_dec_state = S_HALT;
      default: w_dec_state = S_FAULT;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    sense_d = sense_q;
    case (state_q)
      S_IF: begin
        if (mem_ready_i)    state_d = S_ID;
        else if (w_timeout) state_d = S_FAULT;
      end
      S_ID: begin
        if (mem_ready_i) begin
          state_d = w_dec_state;
          alu_d   = w_dec_alu;
          sense_d = w_dec_sense;
        end else if (w_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_EX_STA: begin
        if (mem_ready_i)    state_d = S_IF;
        else if (w_timeout) state_d = S_FAULT;
      end
      S_EX_ALU, S_EX_LDA, S_EX_JMP, S_EX_BR: state_d = S_IF;
      S_HALT:  if (resume_i) state_d = S_IF;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IF;
      alu_q   <= 3'b000;
      sense_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      sense_q <= sense_d;
    end
  end

  // Output decode
  always_comb begin
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    IorD_o     = 1'b0;
    ldIR_o     = 1'b0;
    ldMDR_o    = 1'b0;
    ldAcc_o    = 1'b0;
    AccSrc_o   = 1'b0;
    Asrc_o     = 1'b0;
    Bsrc_o     = BSRC_MDR;
    ALUop_o    = ALU_ADD;
    PCsrc_o    = 1'b0;
    PCwrite_o  = 1'b0;
    halted_o   = 1'b0;
    fault_o    = 1'b0;
    case (state_q)
      S_IF: begin
        // PC + 1 is computed every fetch cycle but committed only with ready
        MemRead_o = 1'b1;
        Bsrc_o    = BSRC_ONE;
        ldIR_o    = mem_ready_i;
        PCwrite_o = mem_ready_i;
      end
      S_ID: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        ldMDR_o   = mem_ready_i;
      end
      S_EX_ALU: begin
        Asrc_o  = 1'b1;
        ALUop_o = alu_q;
        ldAcc_o = 1'b1;
      end
      S_EX_LDA: begin
        ldAcc_o  = 1'b1;
        AccSrc_o = 1'b1;
      end
      S_EX_STA: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_EX_JMP: begin
        PCsrc_o   = 1'b1;
        PCwrite_o = 1'b1;
      end
      S_EX_BR: begin
        PCsrc_o   = 1'b1;
        PCwrite_o = sense_q ? ~zero_i : zero_i;
      end
      S_HALT:  halted_o = 1'b1;
      S_FAULT: fault_o  = 1'b1;
      default: fault_o  = 1'b1;
    endcase
  end

endmodule : acc_ctrl_fsm
`default_nettype wire

// File: tb/tb_acc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_ctrl_fsm
// Description : Self-checking bench for acc_ctrl_fsm. Two instances share
//               stimulus: u_dut (extended set enabled) and u_dut_noext
//               (extended set disabled). Outputs are packed into a 17-bit
//               word {MemRead, MemWrite, IorD, ldIR, ldMDR, ldAcc, AccSrc,
//               Asrc, Bsrc[1:0], ALUop[2:0], PCsrc, PCwrite, halted, fault}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       resume = 1'b0;

  logic       mr0, mw0, iord0, ldir0, ldmdr0, ldacc0, accsrc0, asrc0, pcsrc0, pcw0, hlt0, flt0;
  logic [1:0] bsrc0;
  logic [2:0] alu0;
  logic       mr1, mw1, iord1, ldir1, ldmdr1, ldacc1, accsrc1, asrc1, pcsrc1, pcw1, hlt1, flt1;
  logic [1:0] bsrc1;
  logic [2:0] alu1;

  always #5 clk = ~clk;

  acc_ctrl_fsm u_dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready), .resume_i(resume),
    .MemRead_o(mr0), .MemWrite_o(mw0), .IorD_o(iord0), .ldIR_o(ldir0),
    .ldMDR_o(ldmdr0), .ldAcc_o(ldacc0), .AccSrc_o(accsrc0), .Asrc_o(asrc0),
    .Bsrc_o(bsrc0), .ALUop_o(alu0), .PCsrc_o(pcsrc0), .PCwrite_o(pcw0),
    .halted_o(hlt0), .fault_o(flt0)
  );

  acc_ctrl_fsm #(.WAIT_W(4), .TIMEOUT_EN(1'b1), .ENABLE_EXT(1'b0)) u_dut_noext (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready), .resume_i(resume),
    .MemRead_o(mr1), .MemWrite_o(mw1), .IorD_o(iord1), .ldIR_o(ldir1),
    .ldMDR_o(ldmdr1), .ldAcc_o(ldacc1), .AccSrc_o(accsrc1), .Asrc_o(asrc1),
    .Bsrc_o(bsrc1), .ALUop_o(alu1), .PCsrc_o(pcsrc1), .PCwrite_o(pcw1),
    .halted_o(hlt1), .fault_o(flt1)
  );

  wire logic [16:0] obs0 = {mr0, mw0, iord0, ldir0, ldmdr0, ldacc0, accsrc0, asrc0,
                            bsrc0, alu0, pcsrc0, pcw0, hlt0, flt0};
  wire logic [16:0] obs1 = {mr1, mw1, iord1, ldir1, ldmdr1, ldacc1, accsrc1, asrc1,
                            bsrc1, alu1, pcsrc1, pcw1, hlt1, flt1};

  // Expected output words, hand-derived from the state output tables
  localparam logic [16:0] E_IF_WAIT = 17'h10080;  // MemRead, Bsrc=01
  localparam logic [16:0] E_IF_RDY  = 17'h12084;  // + ldIR, PCwrite
  localparam logic [16:0] E_ID_WAIT = 17'h14000;  // MemRead, IorD
  localparam logic [16:0] E_ID_RDY  = 17'h15000;  // + ldMDR
  localparam logic [16:0] E_ALU_ADD = 17'h00A00;  // Asrc, ldAcc, ALUop=000
  localparam logic [16:0] E_ALU_SUB = 17'h00A10;
  localparam logic [16:0] E_ALU_AND = 17'h00A20;
  localparam logic [16:0] E_ALU_NOT = 17'h00A30;
  localparam logic [16:0] E_ALU_OR  = 17'h00A40;
  localparam logic [16:0] E_ALU_XOR = 17'h00A50;
  localparam logic [16:0] E_LDA     = 17'h00C00;  // ldAcc, AccSrc
  localparam logic [16:0] E_STA     = 17'h0C000;  // MemWrite, IorD
  localparam logic [16:0] E_PC_TAKE = 17'h0000C;  // PCsrc, PCwrite
  localparam logic [16:0] E_PC_NOT  = 17'h00008;  // PCsrc only
  localparam logic [16:0] E_HALT    = 17'h00002;
  localparam logic [16:0] E_FAULT   = 17'h00001;

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic [16:0] exp_ex;
  } vec_t;

  vec_t vecs[13];

  int n_cmp = 0;
  int n_bad = 0;
  int ldir_seen = 0;
  int pcw_seen  = 0;

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%05h required=%05h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One cycle: sample mid-cycle, then advance past the next rising edge
  task automatic step(input string nm, input logic [16:0] e0);
    @(negedge clk);
    chk(nm, obs0, e0);
    ldir_seen += int'(ldir0);
    pcw_seen  += int'(pcw0);
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input string nm, input logic [16:0] e0, input logic [16:0] e1);
    @(negedge clk);
    chk({nm, "/ext"}, obs0, e0);
    chk({nm, "/noext"}, obs1, e1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    resume = 1'b0;
    zero = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{op: 4'd0,  z: 1'b0, exp_ex: E_ALU_ADD};
    vecs[1]  = '{op: 4'd1,  z: 1'b0, exp_ex: E_ALU_SUB};
    vecs[2]  = '{op: 4'd2,  z: 1'b0, exp_ex: E_ALU_AND};
    vecs[3]  = '{op: 4'd3,  z: 1'b0, exp_ex: E_ALU_NOT};
    vecs[4]  = '{op: 4'd4,  z: 1'b0, exp_ex: E_LDA};
    vecs[5]  = '{op: 4'd5,  z: 1'b0, exp_ex: E_STA};
    vecs[6]  = '{op: 4'd6,  z: 1'b0, exp_ex: E_PC_TAKE};
    vecs[7]  = '{op: 4'd7,  z: 1'b1, exp_ex: E_PC_TAKE};  // JZ taken
    vecs[8]  = '{op: 4'd7,  z: 1'b0, exp_ex: E_PC_NOT};   // JZ not taken
    vecs[9]  = '{op: 4'd8,  z: 1'b1, exp_ex: E_PC_NOT};   // JNZ not taken
    vecs[10] = '{op: 4'd8,  z: 1'b0, exp_ex: E_PC_TAKE};  // JNZ taken
    vecs[11] = '{op: 4'd9,  z: 1'b0, exp_ex: E_ALU_OR};
    vecs[12] = '{op: 4'd10, z: 1'b0, exp_ex: E_ALU_XOR};

    // Reset state
    do_reset();
    step2("reset", E_IF_WAIT, E_IF_WAIT);

    // Three not-ready fetch cycles then ready: ldIR/PCwrite pulse once
    do_reset();
    opcode = 4'd0;
    ldir_seen = 0;
    pcw_seen  = 0;
    for (int i = 0; i < 3; i++) step($sformatf("if_wait%0d", i), E_IF_WAIT);
    mem_ready = 1'b1;
    step("if_ready", E_IF_RDY);
    chk_int("ldir_pulses", ldir_seen, 1);
    chk_int("pcw_pulses", pcw_seen, 1);
    step("wait_id", E_ID_RDY);
    step("wait_ex_add", E_ALU_ADD);

    // Zero-wait program from the table: IF, ID, EX per instruction
    for (int i = 0; i < 13; i++) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      mem_ready = 1'b1;
      step($sformatf("vec%0d_if", i), E_IF_RDY);
      step($sformatf("vec%0d_id", i), E_ID_RDY);
      step($sformatf("vec%0d_ex", i), vecs[i].exp_ex);
    end
    zero = 1'b0;

    // Wait states in ID
    do_reset();
    opcode = 4'd4;
    mem_ready = 1'b1;
    step("idw_if", E_IF_RDY);
    mem_ready = 1'b0;
    step("idw_wait0", E_ID_WAIT);
    step("idw_wait1", E_ID_WAIT);
    mem_ready = 1'b1;
    step("idw_ready", E_ID_RDY);
    step("idw_lda", E_LDA);

    // Timeout in EX_STA: 16 not-ready cycles, fault on the 16th edge, sticky
    do_reset();
    opcode = 4'd5;
    mem_ready = 1'b1;
    step("to_if", E_IF_RDY);
    step("to_id", E_ID_RDY);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step($sformatf("to_sta%0d", i), E_STA);
    step("to_fault0", E_FAULT);
    mem_ready = 1'b1;
    resume = 1'b1;
    step("to_fault1", E_FAULT);
    step("to_fault2", E_FAULT);
    do_reset();
    step("to_cleared", E_IF_WAIT);

    // HALT for five cycles, then resume
    do_reset();
    opcode = 4'd11;
    mem_ready = 1'b1;
    step("h_if", E_IF_RDY);
    step("h_id", E_ID_RDY);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i % 2 == 1);
      step($sformatf("h_halt%0d", i), E_HALT);
    end
    mem_ready = 1'b0;
    resume = 1'b1;
    step("h_resume_cyc", E_HALT);
    resume = 1'b0;
    step("h_after_resume", E_IF_WAIT);

    // resume together with rst while halted
    mem_ready = 1'b1;
    step("hr_if", E_IF_RDY);
    step("hr_id", E_ID_RDY);
    resume = 1'b1;
    rst = 1'b1;
    step("hr_halt", E_HALT);
    rst = 1'b0;
    resume = 1'b0;
    mem_ready = 1'b0;
    step("hr_after", E_IF_WAIT);

    // rst in the middle of a waiting store
    do_reset();
    opcode = 4'd5;
    mem_ready = 1'b1;
    step("rs_if", E_IF_RDY);
    step("rs_id", E_ID_RDY);
    mem_ready = 1'b0;
    step("rs_sta", E_STA);
    rst = 1'b1;
    step("rs_sta_rst", E_STA);
    rst = 1'b0;
    step("rs_after", E_IF_WAIT);

    // Opcode 9: ALU OR with extended set, illegal without
    do_reset();
    opcode = 4'd9;
    mem_ready = 1'b1;
    step2("op9_if", E_IF_RDY, E_IF_RDY);
    step2("op9_id", E_ID_RDY, E_ID_RDY);
    step2("op9_ex", E_ALU_OR, E_FAULT);

    // Opcode 13: illegal in both modes
    do_reset();
    opcode = 4'd13;
    mem_ready = 1'b1;
    step2("op13_if", E_IF_RDY, E_IF_RDY);
    step2("op13_id", E_ID_RDY, E_ID_RDY);
    step2("op13_ex", E_FAULT, E_FAULT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_acc_ctrl_fsm
`default_nettype wire
